// File: rtl/riscv_pkg.sv
// Shared definitions for the 64-bit RV pipeline.
// Contents:
//   XLEN         datapath width
//   op_type_e    decoded instruction class from ID
//   ALU_*        4-bit ALU operation codes as seen by the ALU
//   ex_regs_t    contents of the ID/EX pipeline register
//   alu_op_encode / rs2_used helpers used by the ID/EX stage
package riscv_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        OpRArith = 2'b00,
        OpIArith = 2'b01,
        OpLdSt   = 2'b10,
        OpBranch = 2'b11
    } op_type_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b1101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } ex_regs_t;

    // I-arith only keeps funct7_5 for the shift-right pair; elsewhere that bit
    // belongs to the immediate and must not turn e.g. addi into sub.
    function automatic logic [3:0] alu_op_encode(input logic [1:0] op_type,
                                                 input logic [2:0] funct3,
                                                 input logic       funct7_5);
        logic [3:0] op;
        op = ALU_ADD;
        unique case (op_type_e'(op_type))
            OpRArith: op = {funct7_5, funct3};
            OpIArith: op = (funct3 == 3'b101) ? {funct7_5, 3'b101} : {1'b0, funct3};
            OpLdSt:   op = ALU_ADD;
            OpBranch: op = ALU_SUB;
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic rs2_used(input logic [1:0] op_type, input logic mem_write);
        return (op_type == OpRArith) || (op_type == OpBranch) || mem_write;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
// Ports:
//   mem_reg_write/mem_rd/mem_result  EX/MEM forward source (highest priority)
//   wb_reg_write/wb_rd/wb_result     MEM/WB forward source
//   rs                               source register address held in EX
//   reg_data                         operand captured at ID
//   data_out                         resolved operand
module fwd_mux
    import riscv_pkg::*;
(
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] reg_data,
    output logic [XLEN-1:0] data_out
);

    logic hit_mem;
    logic hit_wb;

    // x0 is hard-wired zero, so a pending write to it must never forward.
    assign hit_mem = mem_reg_write && (mem_rd == rs) && (rs != 5'd0);
    assign hit_wb  = wb_reg_write && (wb_rd == rs) && (rs != 5'd0);

    always_comb begin
        data_out = reg_data;
        if (hit_mem) begin
            data_out = mem_result;
        end else if (hit_wb) begin
            data_out = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Captures decoded operands/control from ID, encodes the ALU op, resolves
// MEM/WB forwarding in EX, detects load-use hazards and honours flushes.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_*                               decoded instruction from ID
//   flush                              taken branch in EX; squash ID
//   mem_reg_write/mem_rd/mem_result    EX/MEM forward source
//   wb_reg_write/wb_rd/wb_result       MEM/WB forward source
//   hazard_stall                       hold PC and IF/ID this cycle
//   ex_valid, ex_pc, ex_rd             EX instruction state
//   ex_data1, ex_data2, ex_alu_op      ALU operands and operation
//   ex_store_data                      forwarded rs2 for stores
//   ex_reg_write..ex_mem_to_reg        control, gated by ex_valid
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [1:0]      id_op_type,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            flush,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_data1,
    output logic [XLEN-1:0] ex_data2,
    output logic [3:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg
);

    ex_regs_t ex_q;
    ex_regs_t ex_d;

    logic            load_in_ex;
    logic            rs1_dep;
    logic            rs2_dep;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load-use detection uses the gated load flag so a bubble never stalls.
    assign load_in_ex = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0);
    assign rs1_dep    = (ex_q.rd == id_rs1);
    assign rs2_dep    = (ex_q.rd == id_rs2) && rs2_used(id_op_type, id_mem_write);
    // Flush squashes the dependent instruction anyway, so it must not stall.
    assign hazard_stall = load_in_ex && id_valid && (rs1_dep || rs2_dep) && !flush;

    always_comb begin
        ex_d = ex_q;
        if (flush || hazard_stall) begin
            // Bubble: data fields keep stale values, only validity/control drop.
            ex_d.valid      = 1'b0;
            ex_d.reg_write  = 1'b0;
            ex_d.mem_read   = 1'b0;
            ex_d.mem_write  = 1'b0;
            ex_d.mem_to_reg = 1'b0;
        end else begin
            ex_d.valid      = id_valid;
            ex_d.pc         = id_pc;
            ex_d.imm        = id_imm;
            ex_d.rs1        = id_rs1;
            ex_d.rs2        = id_rs2;
            ex_d.rd         = id_rd;
            ex_d.alu_op     = alu_op_encode(id_op_type, id_funct3, id_funct7_5);
            ex_d.alu_src    = id_alu_src;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            // Register file is not write-through: pick up the WB write here.
            ex_d.rs1_data = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1)) ?
                            wb_result : id_rs1_data;
            ex_d.rs2_data = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2)) ?
                            wb_result : id_rs2_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .rs            (ex_q.rs1),
        .reg_data      (ex_q.rs1_data),
        .data_out      (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .rs            (ex_q.rs2),
        .reg_data      (ex_q.rs2_data),
        .data_out      (fwd_rs2)
    );

    assign ex_valid      = ex_q.valid;
    assign ex_data1      = fwd_rs1;
    assign ex_data2      = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_pc         = ex_q.pc;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write  && ex_q.valid;
    assign ex_mem_read   = ex_q.mem_read   && ex_q.valid;
    assign ex_mem_write  = ex_q.mem_write  && ex_q.valid;
    assign ex_mem_to_reg = ex_q.mem_to_reg && ex_q.valid;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 64-bit RV pipeline, sitting directly upstream of the ALU. It captures decoded operands and control from ID and encodes the 4-bit ALU operation. In EX it resolves operand forwarding from the MEM and WB stages and drives the ALU's data1/data2/ALUOp. It also detects load-use hazards, inserting a bubble and stalling upstream, and honours branch flushes.

## Interface
- XLEN, 64, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN  PC, register-file reads, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register addresses
- id_funct3  in  3; id_funct7_5  in  1  instruction fields
- id_op_type  in  2  00 R-arith, 01 I-arith, 10 load/store, 11 branch
- id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- flush  in  1  branch taken in EX; squash ID instruction
- mem_reg_write  in  1; mem_rd  in  5; mem_result  in  XLEN  EX/MEM forward source
- wb_reg_write  in  1; wb_rd  in  5; wb_result  in  XLEN  MEM/WB forward source
- hazard_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_data1, ex_data2  out  XLEN  ALU operands
- ex_alu_op  out  4  ALU operation
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_pc  out  XLEN; ex_rd  out  5
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  gated by ex_valid

## Operation
- ALU op encoding: R-arith gives {funct7_5, funct3}. I-arith gives {funct7_5, 101} when funct3 = 101, otherwise {0, funct3}. Load/store gives 0000 (add). Branch gives 1000 (sub).
- ID capture bypass: the register file is not write-through. If wb_reg_write is set, wb_rd ≠ 0, and wb_rd equals id_rs1 (or id_rs2), the block captures wb_result in place of the file value.
- EX forwarding, per source register r:
  - If mem_reg_write is set, mem_rd = r, and r ≠ 0, use mem_result.
  - Else if wb_reg_write is set, wb_rd = r, and r ≠ 0, use wb_result.
  - Otherwise use the captured value.
  - MEM always beats WB. x0 never forwards.
- ex_data1 = fwd(rs1). ex_data2 = ex_alu_src ? ex_imm : fwd(rs2). ex_store_data = fwd(rs2) always.
- rs2 is used when op_type is 00 or 11, or when mem_write is set.
- Load-use hazard: hazard_stall is asserted when all of the following hold:
  - ex_valid and ex_mem_read are set, and ex_rd ≠ 0;
  - id_valid is set;
  - ex_rd = id_rs1, or ex_rd = id_rs2 with rs2 used;
  - flush is not set.
- Next-state priority:
  1. flush: bubble.
  2. hazard_stall: bubble.
  3. Otherwise load ID fields, with ex_valid ← id_valid.
- Bubble: ex_valid ← 0 and all four control outputs ← 0. Data registers may hold stale values.
- Control outputs are always ANDed with ex_valid.

## Timing
- Reset: every register and output is 0, so ex_alu_op = 0000 and hazard_stall = 0. Reset takes effect immediately and asynchronously, even mid-instruction.
- Capture latency: 1 cycle from ID to the ex_* outputs.
- ex_data1, ex_data2 and ex_store_data are combinational from the pipeline registers and the mem_*/wb_* inputs, with zero-cycle forwarding.
- hazard_stall is combinational from the ID inputs and the EX registers. It lasts exactly 1 cycle per load-use pair, because the bubble clears ex_mem_read.
- flush together with hazard_stall: flush wins and stall is 0, so the upstream squash proceeds.

## Structure
- Shared package riscv_pkg holds:
  - ALU op constants: ADD 0000, SUB 1000, SLL 0001, SLT 0010, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111;
  - the op_type encoding;
  - XLEN.
- Sub-module fwd_mux: a combinational 3-way priority select (MEM, WB, register value with the x0 guard), instantiated twice.

## Test plan
- R-type sub, funct7_5 = 1, funct3 = 000, rs1 = 10, rs2 = 3 → next cycle ex_alu_op = 1000, ex_data1 = 10, ex_data2 = 3.
- I-type srai (funct7_5 = 1, funct3 = 101) with imm = 4, alu_src = 1 → ex_alu_op = 1101, ex_data2 = 4. Addi with funct7_5 = 1 (immediate bit) → 0000.
- Forwarding: ex_rs1 = 5 with mem_rd = 5 (result 0x11) and wb_rd = 5 (result 0x22), both writing → ex_data1 = 0x11. With mem_reg_write = 0 → 0x22. Same case with rd = 0 → captured value.
- Load-use: ld x7 in EX, add x8, x7, x1 in ID → hazard_stall = 1 for 1 cycle. Next cycle ex_valid = 0 and ex_reg_write = 0. The add then issues with ex_data1 = wb_result through WB forwarding.
- Flush with load-use pending: flush = 1 → hazard_stall = 0, next ex_valid = 0. The ID store is squashed, so no ex_mem_write pulse occurs.
- rst_n low mid-stream → all outputs 0 immediately. The first valid instruction after release appears 1 cycle after capture.
